// File: rtl/u_denorm_pkg.sv
// Shared constants and types for the double-to-fixed-point denormaliser.
package u_denorm_pkg;

    localparam int BIAS  = 1023;
    localparam int EXP_W = 11;
    localparam int MAN_W = 52;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_UNDER = 1;
    localparam int FLAG_RANGE = 2;

    // Field order matches FLAG_* indices: {range, underflow, zero}.
    typedef struct packed {
        logic range_f;
        logic under_f;
        logic zero_f;
    } flags_t;

    typedef struct packed {
        logic             valid;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
        logic             rnd;
    } s1_t;

endpackage

// File: rtl/u_denorm_shift.sv
// Combinational shift/round/saturate: turns a decoded double into F = x*2^W
// (truncated or rounded half-up) plus exactly one or no flag.
module u_denorm_shift
    import u_denorm_pkg::*;
#(
    parameter int W = 105
) (
    input  logic             sign_i,
    input  logic [EXP_W-1:0] exp_i,
    input  logic [MAN_W-1:0] man_i,
    input  logic             rnd_i,
    output logic [W-1:0]     f_o,
    output flags_t           flags_o
);

    localparam int               EXT_W  = W + MAN_W + 1;
    localparam logic [EXP_W-1:0] W_E    = EXP_W'(W);
    localparam logic [EXP_W-1:0] BIAS_E = EXP_W'(BIAS);

    logic [EXP_W-1:0] shift;
    logic [EXT_W-1:0] sig_ext;
    logic [W:0]       win;
    logic [W:0]       sum;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path infers a latch.
        shift   = BIAS_E - exp_i;
        sig_ext = {1'b1, man_i, {W{1'b0}}};
        // win = floor(x*2^(W+1)): F in win[W:1], most significant dropped bit in win[0].
        win     = (W+1)'(sig_ext >> (shift + EXP_W'(MAN_W - 1)));
        sum     = {1'b0, win[W:1]} + {{W{1'b0}}, rnd_i & win[0]};
        f_o     = sum[W] ? {W{1'b1}} : sum[W-1:0];
        flags_o = '0;

        if (sign_i || exp_i >= BIAS_E) begin
            f_o             = {W{1'b1}};
            flags_o.range_f = 1'b1;
        end else if (exp_i == '0) begin
            f_o            = '0;
            flags_o.zero_f = 1'b1;
        end else if (shift > W_E) begin
            f_o             = '0;
            flags_o.under_f = 1'b1;
        end
    end

endmodule

// File: rtl/u_denorm_pipe.sv
// Two-stage pipeline converting an IEEE-754 double in [0,1) into a table
// index (v_out) and fractional delta, with a downstream hold (stopin).
module u_denorm_pipe
    import u_denorm_pkg::*;
#(
    parameter int IDX_W   = 9,
    parameter int DELTA_W = 96
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pushin,
    input  logic [63:0]        u_in,
    input  logic               rnd,
    input  logic               stopin,
    output logic               stopout,
    output logic               pushout,
    output logic [IDX_W-1:0]   v_out,
    output logic [DELTA_W-1:0] delta,
    output logic [2:0]         flags
);

    localparam int W = IDX_W + DELTA_W;

    s1_t          s1_q, s1_d;
    logic         s2_valid_q, s2_valid_d;
    logic [W-1:0] f_q, f_d, f_calc;
    flags_t       flags_q, flags_d, flags_calc;

    u_denorm_shift #(.W(W)) u_shift (
        .sign_i  (s1_q.sign),
        .exp_i   (s1_q.exp),
        .man_i   (s1_q.man),
        .rnd_i   (s1_q.rnd),
        .f_o     (f_calc),
        .flags_o (flags_calc)
    );

    always_comb begin
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        f_d        = f_q;
        flags_d    = flags_q;

        // A hold freezes both stages; a pushin during a hold is dropped.
        if (!stopin) begin
            s1_d.valid = pushin;
            if (pushin) begin
                s1_d.sign = u_in[63];
                s1_d.exp  = u_in[62 -: EXP_W];
                s1_d.man  = u_in[MAN_W-1:0];
                s1_d.rnd  = rnd;
            end
            s2_valid_d = s1_q.valid;
            if (s1_q.valid) begin
                f_d     = f_calc;
                flags_d = flags_calc;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            f_q        <= '0;
            flags_q    <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            f_q        <= f_d;
            flags_q    <= flags_d;
        end
    end

    assign stopout = stopin;
    assign pushout = s2_valid_q;
    assign v_out   = f_q[W-1:DELTA_W];
    assign delta   = f_q[DELTA_W-1:0];
    assign flags   = flags_q;

endmodule
